// File: rtl/fdiv4.sv
// Floating-point divide-by-4 stage: subtracts 2 from the exponent, with gradual
// underflow into subnormals and truncation of the bits shifted out; registered output.
module fdiv4 #(
    parameter int I_EXP  = 8,
    parameter int I_MNT  = 7,
    parameter int I_DATA = I_EXP + I_MNT + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic [I_DATA-1:0] if32,
    output logic              o_vld,
    output logic [I_DATA-1:0] of32
);

    localparam logic [I_EXP-1:0] EXP_ZERO = '0;
    localparam logic [I_EXP-1:0] EXP_ONE  = I_EXP'(1);
    localparam logic [I_EXP-1:0] EXP_TWO  = I_EXP'(2);

    logic              in_sign;
    logic [I_EXP-1:0]  in_exp;
    logic [I_MNT-1:0]  in_mnt;
    logic [I_MNT:0]    in_sig;
    logic [I_MNT:0]    sig_shr1;
    logic [I_MNT:0]    sig_shr2;
    logic [I_EXP-1:0]  res_exp;
    logic [I_MNT-1:0]  res_mnt;

    logic              o_vld_d, o_vld_q;
    logic [I_DATA-1:0] of32_d, of32_q;

    // Exponents 1 and 2 drop into the subnormal range, so the hidden bit is
    // shifted into the stored mantissa; exponent 0 just shifts the stored bits.
    always_comb begin
        in_sign  = if32[I_DATA-1];
        in_exp   = if32[I_DATA-2 -: I_EXP];
        in_mnt   = if32[I_MNT-1:0];
        in_sig   = {1'b1, in_mnt};
        sig_shr1 = in_sig >> 1;
        sig_shr2 = in_sig >> 2;
        res_exp  = EXP_ZERO;
        res_mnt  = in_mnt;
        if (in_exp == EXP_ZERO) begin
            res_mnt = in_mnt >> 2;
        end else if (in_exp == EXP_ONE) begin
            res_mnt = sig_shr2[I_MNT-1:0];
        end else if (in_exp == EXP_TWO) begin
            res_mnt = sig_shr1[I_MNT-1:0];
        end else begin
            res_exp = in_exp - EXP_TWO;
        end
    end

    always_comb begin
        o_vld_d = i_vld;
        of32_d  = of32_q;
        if (i_vld) begin
            of32_d = {in_sign, res_exp, res_mnt};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld_q <= 1'b0;
            of32_q  <= '0;
        end else begin
            o_vld_q <= o_vld_d;
            of32_q  <= of32_d;
        end
    end

    assign o_vld = o_vld_q;
    assign of32  = of32_q;

endmodule

// File: tb/tb_fdiv4.sv
// Self-checking bench for fdiv4: directed vectors, control sequences and a
// randomized stream checked against a scaled-integer reference model.
module tb_fdiv4;

    localparam int I_EXP  = 8;
    localparam int I_MNT  = 7;
    localparam int I_DATA = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_vld;
    logic [I_DATA-1:0] if32;
    logic              o_vld;
    logic [I_DATA-1:0] of32;

    int compared   = 0;
    int mismatched = 0;

    logic              exp_vld;
    logic [I_DATA-1:0] exp_of;

    fdiv4 #(.I_EXP(I_EXP), .I_MNT(I_MNT), .I_DATA(I_DATA)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_vld (i_vld),
        .if32  (if32),
        .o_vld (o_vld),
        .of32  (of32)
    );

    always #5 clk = ~clk;

    // Value measured in units of the smallest subnormal step: a subnormal is M units,
    // a normal with exponent E is (2^I_MNT + M) * 2^(E-1) units. Quartering while still
    // subnormal is a truncating integer divide; larger exponents simply drop by 2.
    function automatic logic [I_DATA-1:0] ref_div4(input logic [I_DATA-1:0] x);
        int e;
        int m;
        int units;
        e = int'(x[I_DATA-2 -: I_EXP]);
        m = int'(x[I_MNT-1:0]);
        if (e >= 3) return {x[I_DATA-1], I_EXP'(e - 2), x[I_MNT-1:0]};
        units = (e == 0) ? m : (((1 << I_MNT) + m) << (e - 1));
        return {x[I_DATA-1], I_EXP'(0), I_MNT'(units / 4)};
    endfunction

    function automatic logic [I_DATA-1:0] mk(input logic s, input logic [I_EXP-1:0] e,
                                             input logic [I_MNT-1:0] m);
        return {s, e, m};
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic [I_DATA-1:0] d);
        @(negedge clk);
        rst   = r;
        i_vld = v;
        if32  = d;
        @(posedge clk);
        #1;
        if (r) begin
            exp_vld = 1'b0;
            exp_of  = '0;
        end else begin
            exp_vld = v;
            if (v) exp_of = ref_div4(d);
        end
    endtask

    task automatic checkOutput(input string tag);
        compared++;
        assert (o_vld === exp_vld) else begin
            mismatched++;
            $display("[TB] FAIL %s o_vld: observed %b expected %b", tag, o_vld, exp_vld);
            $error("[TB] o_vld wrong at %s", tag);
        end
        compared++;
        assert (of32 === exp_of) else begin
            mismatched++;
            $display("[TB] FAIL %s of32: observed %h expected %h", tag, of32, exp_of);
            $error("[TB] of32 wrong at %s", tag);
        end
    endtask

    task automatic directed(input string tag, input logic [I_DATA-1:0] d,
                            input logic [I_DATA-1:0] want);
        applyStimulus(1'b0, 1'b1, d);
        checkOutput(tag);
        compared++;
        assert (of32 === want) else begin
            mismatched++;
            $display("[TB] FAIL %s literal: observed %h expected %h", tag, of32, want);
            $error("[TB] of32 differs from table value at %s", tag);
        end
    endtask

    initial begin
        logic r;
        logic v;
        logic [I_DATA-1:0] d;

        rst     = 1'b1;
        i_vld   = 1'b0;
        if32    = '0;
        exp_vld = 1'b0;
        exp_of  = '0;

        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("reset");

        directed("sub_pos",  mk(0, 8'd0,   7'h7F), mk(0, 8'd0,   7'h1F));
        directed("sub_neg",  mk(1, 8'd0,   7'h7F), mk(1, 8'd0,   7'h1F));
        directed("e1_pos",   mk(0, 8'd1,   7'h7F), mk(0, 8'd0,   7'h3F));
        directed("e1_neg",   mk(1, 8'd1,   7'h7F), mk(1, 8'd0,   7'h3F));
        directed("e2_pos",   mk(0, 8'd2,   7'h7F), mk(0, 8'd0,   7'h7F));
        directed("e2_neg",   mk(1, 8'd2,   7'h7F), mk(1, 8'd0,   7'h7F));
        directed("norm_pos", mk(0, 8'h21,  7'h7F), mk(0, 8'h1F,  7'h7F));
        directed("norm_neg", mk(1, 8'h21,  7'h7F), mk(1, 8'h1F,  7'h7F));
        directed("max_exp",  mk(0, 8'hFF,  7'h7F), mk(0, 8'hFD,  7'h7F));
        directed("e3",       mk(0, 8'd3,   7'h55), mk(0, 8'd1,   7'h55));
        directed("pos_zero", 16'h0000, 16'h0000);
        directed("neg_zero", 16'h8000, 16'h8000);
        directed("e1_trunc", mk(0, 8'd1,   7'h00), mk(0, 8'd0,   7'h20));
        directed("sub_trunc", mk(0, 8'd0,  7'h03), mk(0, 8'd0,   7'h00));

        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("reset_again");
        directed("stream0", mk(0, 8'h80, 7'h12), mk(0, 8'h7E, 7'h12));
        directed("stream1", mk(1, 8'd1,  7'h40), mk(1, 8'd0,  7'h30));
        directed("stream2", mk(0, 8'd2,  7'h01), mk(0, 8'd0,  7'h40));
        applyStimulus(1'b0, 1'b0, 16'hABCD);
        checkOutput("idle_hold");
        applyStimulus(1'b0, 1'b0, 16'h1234);
        checkOutput("idle_hold2");
        applyStimulus(1'b1, 1'b1, 16'h4321);
        checkOutput("reset_drops_operand");
        applyStimulus(1'b0, 1'b0, 16'h4321);
        checkOutput("after_reset_idle");

        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 24) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = I_DATA'($urandom);
            if ($urandom_range(0, 3) == 0) d[I_DATA-2 -: I_EXP] = I_EXP'($urandom_range(0, 3));
            applyStimulus(r, v, d);
            checkOutput("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
